// File: rtl/icache_pkg.sv
// Shared constants and FSM encoding for the instruction cache.
package icache_pkg;

  localparam bit True  = 1'b1;
  localparam bit False = 1'b0;

  localparam int LINE_OFF_W     = 4;
  localparam int WORDS_PER_LINE = 4;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } state_e;

endpackage

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: combinational lookup on pc,
// single outstanding 4-beat line fill installed atomically on the last beat.
module icache
  import icache_pkg::*;
#(
  parameter int INDEX_WIDTH = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [31:0] pc,
  output logic        icache_hit,
  output logic [31:0] icache_inst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_word_valid,
  input  logic [31:0] mem_word
);

  localparam int LINES  = 1 << INDEX_WIDTH;
  localparam int TAG_W  = 32 - LINE_OFF_W - INDEX_WIDTH;
  localparam int LINE_W = 32 - LINE_OFF_W;

  logic [INDEX_WIDTH-1:0] lk_idx;
  logic [TAG_W-1:0]       lk_tag;
  logic [1:0]             lk_word;

  logic [LINES-1:0]                      valid_q;
  logic [TAG_W-1:0]                      tag_q  [LINES];
  logic [WORDS_PER_LINE-1:0][31:0]       data_q [LINES];
  logic [WORDS_PER_LINE-1:0][31:0]       buf_q;

  state_e              state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                req_q, req_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic                install;
  logic                beat;

  logic [INDEX_WIDTH-1:0] fill_idx;
  logic [TAG_W-1:0]       fill_tag;
  logic                   unused_pc_bits;

  assign lk_word = pc[LINE_OFF_W-1:2];
  assign lk_idx  = pc[LINE_OFF_W +: INDEX_WIDTH];
  assign lk_tag  = pc[LINE_OFF_W+INDEX_WIDTH +: TAG_W];
  assign unused_pc_bits = ^pc[1:0];

  assign fill_idx = line_q[INDEX_WIDTH-1:0];
  assign fill_tag = line_q[INDEX_WIDTH +: TAG_W];

  assign icache_hit  = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign icache_inst = icache_hit ? data_q[lk_idx][lk_word] : 32'h0;

  assign mem_req  = req_q;
  assign mem_addr = {line_q, {LINE_OFF_W{1'b0}}};

  assign beat = rdy && (state_q == S_FILL) && mem_word_valid;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    line_d  = line_q;
    install = 1'b0;
    if (rdy) begin
      case (state_q)
        S_IDLE: begin
          if (!icache_hit) begin
            line_d  = pc[31:LINE_OFF_W];
            req_d   = 1'b1;
            cnt_d   = 2'd0;
            state_d = S_FILL;
          end
        end
        S_FILL: begin
          if (mem_word_valid) begin
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
              install = 1'b1;
              req_d   = 1'b0;
              state_d = S_IDLE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
      req_q   <= 1'b0;
      line_q  <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      line_q  <= line_d;
      if (install) valid_q[fill_idx] <= 1'b1;
    end
  end

  // Storage arrays need no reset: valid bits gate every lookup.
  always_ff @(posedge clk) begin
    if (beat) buf_q[cnt_q] <= mem_word;
    if (install) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= {mem_word, buf_q[2], buf_q[1], buf_q[0]};
    end
  end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed vector table, hand-written fill
// corner cases and randomized traffic against a line-level reference model.
module tb_icache;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic [31:0] pc;
  logic        icache_hit;
  logic [31:0] icache_inst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_word_valid;
  logic [31:0] mem_word;

  int checks = 0;
  int errors = 0;

  icache #(.INDEX_WIDTH(6)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .pc(pc),
    .icache_hit(icache_hit), .icache_inst(icache_inst),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_word_valid(mem_word_valid), .mem_word(mem_word)
  );

  always #5 clk = ~clk;

  // Reference model: a table of cached lines plus the in-flight fill.
  bit          m_valid [64];
  logic [21:0] m_tag   [64];
  logic [31:0] m_data  [64][4];
  bit          m_busy;
  logic [31:0] m_addr;
  logic [31:0] m_words [$];

  function automatic bit m_hit(logic [31:0] a);
    return m_valid[a[9:4]] && (m_tag[a[9:4]] == a[31:10]);
  endfunction

  function automatic logic [31:0] m_inst(logic [31:0] a);
    return m_hit(a) ? m_data[a[9:4]][a[3:2]] : 32'h0;
  endfunction

  task automatic model_reset();
    foreach (m_valid[i]) m_valid[i] = 1'b0;
    m_busy = 1'b0;
    m_addr = 32'h0;
    m_words.delete();
  endtask

  task automatic model_step();
    if (rdy) begin
      if (!m_busy) begin
        if (!m_hit(pc)) begin
          m_busy = 1'b1;
          m_addr = {pc[31:4], 4'h0};
          m_words.delete();
        end
      end else if (mem_word_valid) begin
        m_words.push_back(mem_word);
        if (m_words.size() == 4) begin
          m_valid[m_addr[9:4]] = 1'b1;
          m_tag[m_addr[9:4]]   = m_addr[31:10];
          for (int k = 0; k < 4; k++) m_data[m_addr[9:4]][k] = m_words[k];
          m_busy = 1'b0;
        end
      end
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_model(string name);
    chk({name, ".hit"},  {31'h0, icache_hit}, {31'h0, m_hit(pc)});
    chk({name, ".inst"}, icache_inst, m_inst(pc));
    chk({name, ".req"},  {31'h0, mem_req}, {31'h0, m_busy});
    if (m_busy) chk({name, ".addr"}, mem_addr, m_addr);
  endtask

  task automatic drive(logic [31:0] p, bit r, bit v, logic [31:0] w);
    pc = p; rdy = r; mem_word_valid = v; mem_word = w;
    #1;
  endtask

  task automatic advance();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    chk("reset.req",  {31'h0, mem_req}, 32'h0);
    chk("reset.addr", mem_addr, 32'h0);
    chk("reset.hit",  {31'h0, icache_hit}, 32'h0);
    chk("reset.inst", icache_inst, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic fill_line(logic [31:0] a, logic [31:0] base);
    drive(a, 1'b1, 1'b0, 32'h0);
    advance();
    for (int k = 0; k < 4; k++) begin
      drive(a, 1'b1, 1'b1, base + k);
      check_model("fill");
      advance();
    end
  endtask

  typedef struct {
    logic [31:0] pc;
    bit          vld;
    logic [31:0] w;
    bit          e_hit;
    logic [31:0] e_inst;
    bit          e_req;
    logic [31:0] e_addr;
  } vec_t;

  vec_t tbl [17];

  initial begin
    tbl[0]  = '{32'h100, 1'b1, 32'hDEAD, 1'b0, 32'h0,  1'b0, 32'h0};
    tbl[1]  = '{32'h100, 1'b1, 32'hA,    1'b0, 32'h0,  1'b1, 32'h100};
    tbl[2]  = '{32'h100, 1'b1, 32'hB,    1'b0, 32'h0,  1'b1, 32'h100};
    tbl[3]  = '{32'h100, 1'b1, 32'hC,    1'b0, 32'h0,  1'b1, 32'h100};
    tbl[4]  = '{32'h100, 1'b1, 32'hD,    1'b0, 32'h0,  1'b1, 32'h100};
    tbl[5]  = '{32'h10C, 1'b0, 32'h0,    1'b1, 32'hD,  1'b0, 32'h0};
    tbl[6]  = '{32'h104, 1'b0, 32'h0,    1'b1, 32'hB,  1'b0, 32'h0};
    tbl[7]  = '{32'h108, 1'b1, 32'h77,   1'b1, 32'hC,  1'b0, 32'h0};
    tbl[8]  = '{32'h100, 1'b0, 32'h0,    1'b1, 32'hA,  1'b0, 32'h0};
    tbl[9]  = '{32'h500, 1'b0, 32'h0,    1'b0, 32'h0,  1'b0, 32'h0};
    tbl[10] = '{32'h500, 1'b1, 32'h11,   1'b0, 32'h0,  1'b1, 32'h500};
    tbl[11] = '{32'h500, 1'b1, 32'h12,   1'b0, 32'h0,  1'b1, 32'h500};
    tbl[12] = '{32'h500, 1'b1, 32'h13,   1'b0, 32'h0,  1'b1, 32'h500};
    tbl[13] = '{32'h500, 1'b1, 32'h14,   1'b0, 32'h0,  1'b1, 32'h500};
    tbl[14] = '{32'h500, 1'b0, 32'h0,    1'b1, 32'h11, 1'b0, 32'h0};
    tbl[15] = '{32'h100, 1'b0, 32'h0,    1'b0, 32'h0,  1'b0, 32'h0};
    tbl[16] = '{32'h100, 1'b0, 32'h0,    1'b0, 32'h0,  1'b1, 32'h100};

    rst = 1'b1; rdy = 1'b1; pc = 32'h0; mem_word_valid = 1'b0; mem_word = 32'h0;
    do_reset();

    // Cold miss, same-line hits, conflict eviction.
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].pc, 1'b1, tbl[i].vld, tbl[i].w);
      chk($sformatf("vec%0d.hit", i),  {31'h0, icache_hit}, {31'h0, tbl[i].e_hit});
      chk($sformatf("vec%0d.inst", i), icache_inst, tbl[i].e_inst);
      chk($sformatf("vec%0d.req", i),  {31'h0, mem_req}, {31'h0, tbl[i].e_req});
      if (tbl[i].e_req) chk($sformatf("vec%0d.addr", i), mem_addr, tbl[i].e_addr);
      check_model($sformatf("vec%0d.mdl", i));
      advance();
    end

    // Redirect mid-fill: the original line still installs.
    do_reset();
    drive(32'h200, 1'b1, 1'b0, 32'h0);
    advance();
    drive(32'h200, 1'b1, 1'b1, 32'h21); advance();
    drive(32'h200, 1'b1, 1'b1, 32'h22); advance();
    drive(32'h300, 1'b1, 1'b1, 32'h23);
    chk("redir.addr_mid", mem_addr, 32'h200);
    check_model("redir");
    advance();
    drive(32'h300, 1'b1, 1'b1, 32'h24); advance();
    drive(32'h300, 1'b1, 1'b0, 32'h0);
    chk("redir.req_gap", {31'h0, mem_req}, 32'h0);
    chk("redir.hit300",  {31'h0, icache_hit}, 32'h0);
    advance();
    drive(32'h300, 1'b1, 1'b0, 32'h0);
    chk("redir.req300",  {31'h0, mem_req}, 32'h1);
    chk("redir.addr300", mem_addr, 32'h300);
    drive(32'h204, 1'b1, 1'b0, 32'h0);
    chk("redir.hit200",  {31'h0, icache_hit}, 32'h1);
    chk("redir.inst204", icache_inst, 32'h22);
    check_model("redir.end");

    // Stalled beats and rdy low.
    do_reset();
    drive(32'h80, 1'b0, 1'b0, 32'h0);
    advance();
    drive(32'h80, 1'b0, 1'b0, 32'h0);
    chk("rdy0.noreq", {31'h0, mem_req}, 32'h0);
    drive(32'h40, 1'b1, 1'b0, 32'h0); advance();
    drive(32'h40, 1'b1, 1'b1, 32'h51); advance();
    drive(32'h40, 1'b1, 1'b0, 32'h0);  advance();
    drive(32'h40, 1'b1, 1'b1, 32'h52); advance();
    for (int k = 0; k < 3; k++) begin
      drive(32'h40, 1'b0, 1'b1, 32'hBAD0 + k);
      check_model("stall.rdy0");
      advance();
    end
    drive(32'h40, 1'b1, 1'b1, 32'h53); advance();
    drive(32'h4C, 1'b1, 1'b0, 32'h0);
    chk("stall.hit3", {31'h0, icache_hit}, 32'h0);
    chk("stall.req3", {31'h0, mem_req}, 32'h1);
    advance();
    drive(32'h4C, 1'b1, 1'b1, 32'h54); advance();
    for (int k = 0; k < 4; k++) begin
      drive(32'h40 + 4 * k, 1'b1, 1'b0, 32'h0);
      chk($sformatf("stall.inst%0d", k), icache_inst, 32'h51 + k);
    end
    check_model("stall.end");

    // Reset mid-fill: partial line discarded, earlier line lost too.
    do_reset();
    fill_line(32'h100, 32'h900);
    drive(32'h100, 1'b1, 1'b0, 32'h0);
    chk("rmid.prehit", {31'h0, icache_hit}, 32'h1);
    drive(32'h180, 1'b1, 1'b0, 32'h0); advance();
    drive(32'h180, 1'b1, 1'b1, 32'h61); advance();
    drive(32'h180, 1'b1, 1'b1, 32'h62); advance();
    rst = 1'b1;
    model_reset();
    #1;
    chk("rmid.req", {31'h0, mem_req}, 32'h0);
    drive(32'h100, 1'b1, 1'b0, 32'h0);
    chk("rmid.hit100", {31'h0, icache_hit}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(32'h180, 1'b1, 1'b0, 32'h0);
    chk("rmid.req_post", {31'h0, mem_req}, 32'h0);
    advance();
    chk("rmid.addr", mem_addr, 32'h180);
    for (int k = 0; k < 3; k++) begin
      drive(32'h180, 1'b1, 1'b1, 32'h71 + k); advance();
    end
    drive(32'h180, 1'b1, 1'b1, 32'h74);
    chk("rmid.hit3beats", {31'h0, icache_hit}, 32'h0);
    advance();
    drive(32'h18C, 1'b1, 1'b0, 32'h0);
    chk("rmid.hit4", {31'h0, icache_hit}, 32'h1);
    chk("rmid.inst", icache_inst, 32'h74);

    // Randomized traffic over a few conflicting lines.
    do_reset();
    begin
      logic [31:0] rpc;
      rpc = 32'h0;
      for (int c = 0; c < 4000; c++) begin
        if ($urandom_range(0, 9) < 3)
          rpc = {20'h0, 2'($urandom_range(0, 2)), 4'h0, 2'($urandom_range(0, 3)),
                 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
        if ($urandom_range(0, 799) == 0) do_reset();
        drive(rpc, $urandom_range(0, 9) != 0, $urandom_range(0, 2) != 0, $urandom);
        check_model("rand");
        advance();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache that answers the instruction fetcher's per-cycle PC lookup and refills missing lines from the memory controller. Hit/instruction are combinational on the presented PC, so the fetcher can issue in the same cycle. A miss starts a single outstanding 4-word line fill, installed atomically on the last beat. Sits between the instruction fetcher (responder side of `pc_to_icache` / `icache_hit` / `icache_inst`) and the memory controller's instruction port.

## Interface
- `INDEX_WIDTH`, 6, line-index bits (2^INDEX_WIDTH lines); tag width = 28 − INDEX_WIDTH
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset
- `rdy`  in  1  global enable; when low, no state changes
- `pc`  in  32  fetch address from fetcher, word aligned (bits [1:0] ignored)
- `icache_hit`  out  1  line holding `pc` is valid and tag matches (combinational)
- `icache_inst`  out  32  instruction word at `pc` when hit, else 0 (combinational)
- `mem_req`  out  1  line-fill request, level, held for the whole fill
- `mem_addr`  out  32  line-aligned fill address, {pc[31:4], 4'b0}
- `mem_word_valid`  in  1  one fill beat delivered this cycle
- `mem_word`  in  32  fill beat data, words in ascending address order

## Operation
- Address split: [1:0] byte (ignored), [3:2] word-in-line, [3+INDEX_WIDTH:4] index, [31:4+INDEX_WIDTH] tag.
- Storage: per line a valid bit, tag, 4×32-bit words. No write path from the core, so no dirty state.
- FSM states: IDLE, FILL.
- IDLE: if `!icache_hit`, latch `mem_addr` = line address of `pc`, set `mem_req`=1, beat count=0 → FILL. On hit, stay.
- FILL: each cycle with `mem_word_valid`, store `mem_word` in fill buffer slot[count], count+1 (2-bit). On the 4th beat, write buffer + tag and set valid for the latched index in the same edge, drop `mem_req`, → IDLE.
- The fill always runs to completion, even if `pc` changes mid-fill (rollback, jalr redirect); the fetched line is installed regardless. No abort, no second outstanding fill.
- No bypass from the fill buffer: `icache_hit` for the filled line first rises after the installing edge.
- Installing over a valid line with a different tag replaces it (direct-mapped eviction).
- `mem_word_valid` while IDLE is ignored.
- `rdy` low: FSM, counter, buffer and arrays hold; beats arriving then are ignored (the memory controller is gated by the same `rdy`). Hit/inst outputs stay combinationally live.

## Timing
- Reset (async, takes effect immediately): all valid bits 0, FSM IDLE, count 0, `mem_req`=0, `mem_addr`=0. Hence `icache_hit`=0 and `icache_inst`=0. Tag/data array contents are don't-care.
- Hit latency: 0 cycles (combinational from `pc`).
- Miss: `mem_req` rises at the first clock edge where IDLE sees the miss.
- Minimum miss penalty, back-to-back beats: `mem_req` edge + 4 beat edges. Hit is visible 5 edges after the miss was first seen.
- Reset mid-fill: fill abandoned, partial line discarded, nothing installed.

## Structure
- The shared defines header (alongside the existing `True`/`False` defines) carries: line byte offset width (4), words per line (4), and the FSM state encodings.
- Arrays, FSM and fill buffer are inline; a sub-module is not natural at this size.

## Test plan
- Cold miss: after reset `pc`=0x0000_0100 → `icache_hit`=0, `mem_req`=1, `mem_addr`=0x100. Beats 0xA,0xB,0xC,0xD. → `mem_req`=0 and `icache_hit`=1 on the next cycle; `pc`=0x10C returns `icache_inst`=0xD.
- Same line: after the fill, `pc`=0x104 and 0x108 → hit in 0 cycles with 0xB / 0xC. No new `mem_req`.
- Conflict eviction (INDEX_WIDTH=6): fill 0x100, then `pc`=0x500 (same index) → miss, fill 0x500. Afterward `pc`=0x100 → miss again.
- Redirect mid-fill: miss on 0x200; after beat 2 switch `pc` to 0x300 → fill completes for 0x200, then IDLE sees the 0x300 miss and requests `mem_addr`=0x300. 0x200 is a hit afterward.
- Stalled beats and `rdy`: insert gaps between beats and hold `rdy`=0 for 3 cycles mid-fill with `mem_word_valid` pulsed → ignored beats are not counted, and the line installs only after 4 accepted beats.
- Reset mid-fill: assert `rst` after beat 2 → `mem_req`=0 immediately and all lookups miss. The next miss restarts a full 4-beat fill.
